// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic result stage: opcodes, flag bit
// positions, the forced divide-by-zero result and the FIFO entry layout.
package arith_pkg;

    // Opcodes as presented by the upstream arithmetic unit
    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    // Bit positions inside the 4-bit flag vector {dz, ovf, carry, zero}
    localparam int FLG_ZERO  = 0;
    localparam int FLG_CARRY = 1;
    localparam int FLG_OVF   = 2;
    localparam int FLG_DZ    = 3;

    localparam int RESULT_W = 8;
    localparam int FLAGS_W  = 4;
    localparam int ENTRY_W  = RESULT_W + FLAGS_W;

    // Result substituted for the unit's output on a divide by zero
    localparam logic [RESULT_W-1:0] DZ_RESULT = 8'hFF;

    // One buffered entry: the selected result and its status flags
    typedef struct packed {
        logic [RESULT_W-1:0] result;
        logic [FLAGS_W-1:0]  flags;
    } entry_t;

    // Assemble the flag vector from its individual conditions
    function automatic logic [FLAGS_W-1:0] pack_flags(
        input logic dz,
        input logic ovf,
        input logic carry,
        input logic zero
    );
        logic [FLAGS_W-1:0] f;
        f            = '0;
        f[FLG_DZ]    = dz;
        f[FLG_OVF]   = ovf;
        f[FLG_CARRY] = carry;
        f[FLG_ZERO]  = zero;
        return f;
    endfunction

endpackage

// File: rtl/arith_fifo.sv
// Small synchronous FIFO with registered storage. The head entry is read
// straight from the storage registers and reads as zero while empty.
module arith_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses pushes even when a pop happens in the same cycle
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Head entry, forced to zero when there is nothing buffered
    always_comb begin
        rdata = '0;
        if (!empty) begin
            rdata = mem[rd_ptr];
        end
    end

    // Storage write; contents cleared on reset so stale data never leaks out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy count; a simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/arith_result_stage.sv
// Registered result stage behind the 8-bit arithmetic unit. Picks the result
// for the opcode, derives status flags from the operands, buffers entries in
// a FIFO with valid/ready on both sides and keeps two debug counters.
module arith_result_stage
    import arith_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [7:0]       i_value_a,
    input  logic [7:0]       i_value_b,
    input  logic [7:0]       i_result_add,
    input  logic [7:0]       i_result_sub,
    input  logic [7:0]       i_result_mul,
    input  logic [7:0]       i_result_div,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [7:0]       o_result,
    output logic [3:0]       o_flags,
    output logic [CNT_W-1:0] o_count_ops,
    output logic [CNT_W-1:0] o_count_dz
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          accept;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic [8:0]    sum9;
    logic [15:0]   product;
    logic          is_dz;

    logic [7:0]    sel_result;
    logic          carry;
    logic          ovf;
    entry_t        wr_entry;
    entry_t        rd_entry;

    // Handshakes: ready depends only on registered occupancy, never on i_ready
    assign o_ready = !fifo_full;
    assign o_valid = !fifo_empty;
    assign accept  = i_valid && o_ready;
    assign pop     = o_valid && i_ready;

    // Local wide arithmetic used only for carry and overflow detection
    assign sum9    = {1'b0, i_value_a} + {1'b0, i_value_b};
    assign product = {8'd0, i_value_a} * {8'd0, i_value_b};
    assign is_dz   = (op_t'(i_op) == OP_DIV) && (i_value_b == 8'd0);

    // Select the unit output for the opcode and derive carry/overflow
    always_comb begin
        sel_result = '0;
        carry      = 1'b0;
        ovf        = 1'b0;
        case (op_t'(i_op))
            OP_ADD: begin
                sel_result = i_result_add;
                carry      = (sum9 > 9'd255);
            end
            OP_SUB: begin
                sel_result = i_result_sub;
                carry      = (i_value_a < i_value_b);
            end
            OP_MUL: begin
                sel_result = i_result_mul;
                ovf        = (product > 16'd255);
            end
            OP_DIV: begin
                if (is_dz) begin
                    sel_result = DZ_RESULT;
                end else begin
                    sel_result = i_result_div;
                end
            end
            default: begin
                sel_result = '0;
            end
        endcase
    end

    // Build the entry to push; zero reflects the final stored result
    always_comb begin
        wr_entry        = '0;
        wr_entry.result = sel_result;
        wr_entry.flags  = pack_flags(is_dz, ovf, carry, (sel_result == 8'd0));
    end

    arith_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (accept),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign o_result = rd_entry.result;
    assign o_flags  = rd_entry.flags;

    // Pop counter wraps; it counts entries actually delivered downstream
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_count_ops <= '0;
        end else if (pop) begin
            o_count_ops <= o_count_ops + CNT_W'(1);
        end
    end

    // Divide-by-zero counter saturates so a flood of bad ops stays visible
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_count_dz <= '0;
        end else if (accept && is_dz && !(&o_count_dz)) begin
            o_count_dz <= o_count_dz + CNT_W'(1);
        end
    end

endmodule

// File: doc/arith_result_stage.md
Name: arith_result_stage

Overview:
Registered result stage directly downstream of the combinational 8-bit arithmetic unit (add/sub/mul/div).
- Receives the unit's four result bytes plus the operands that produced them.
- Selects one result by opcode, computes status flags, defines divide-by-zero behaviour, and buffers results in a small FIFO with a valid/ready handshake toward the consumer.
- Keeps an operation counter and a divide-by-zero counter for debug.

Parameters:
DEPTH, 2, output FIFO entries; power of two, >= 2
CNT_W, 16, width of both statistics counters

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  asynchronous, active-high reset
i_valid  input  1  upstream operands/results valid
o_ready  output  1  stage can accept this cycle
i_op  input  2  0=ADD, 1=SUB, 2=MUL, 3=DIV
i_value_a  input  8  operand A as fed to the arithmetic unit
i_value_b  input  8  operand B as fed to the arithmetic unit
i_result_add  input  8  unit add result
i_result_sub  input  8  unit sub result
i_result_mul  input  8  unit mul result (low byte)
i_result_div  input  8  unit div result
o_valid  output  1  head entry valid
i_ready  input  1  downstream accepts head entry
o_result  output  8  head entry result
o_flags  output  4  head entry flags {dz, ovf, carry, zero}
o_count_ops  output  CNT_W  entries popped
o_count_dz  output  CNT_W  divide-by-zero ops accepted

Behaviour:
- Reset (asynchronous, i_rst=1): FIFO emptied; o_valid=0, o_result=0, o_flags=0, o_count_ops=0, o_count_dz=0, o_ready=1. Reset mid-operation discards all buffered entries. No accept or pop occurs while i_rst is high.
- Accept: push when i_valid && o_ready at a rising edge. o_ready = !full, combinational from the registered count only; it never depends on i_ready. When full, a same-cycle pop does not enable a push.
- Pop: when o_valid && i_ready at a rising edge. o_valid = !empty.
- Latency: an entry accepted at edge N into an empty FIFO shows o_valid=1 in the cycle after edge N.
- Ordering: strict FIFO.
- Simultaneous push and pop when not full and not empty: count unchanged, both happen.
- Empty FIFO: o_result=0, o_flags=0.
- Pointers: wrap modulo DEPTH. Count is held in log2(DEPTH)+1 bits.
- Result select: ADD -> i_result_add; SUB -> i_result_sub; MUL -> i_result_mul.
- DIV: i_result_div when i_value_b != 0. When i_value_b == 0, the result is forced to 8'hFF and i_result_div is ignored.
- Flags, computed locally from operands at accept time:
  - carry: ADD -> bit 8 of the 9-bit sum a+b; SUB -> borrow (a < b); MUL and DIV -> 0.
  - ovf: MUL -> upper byte of the 16-bit product a*b is nonzero; otherwise 0.
  - dz: DIV && b == 0; otherwise 0.
  - zero: final stored result == 0. A forced 8'hFF gives zero=0.
- o_count_ops: +1 per pop; wraps at 2^CNT_W.
- o_count_dz: +1 per accepted DIV with b == 0; saturates at all-ones.
- Registered outputs: counters. o_result and o_flags are read from FIFO storage registers.

Decomposition:
- Package arith_pkg:
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV (2-bit)
  - flag bit indices FLG_ZERO=0, FLG_CARRY=1, FLG_OVF=2, FLG_DZ=3
  - DZ_RESULT=8'hFF
  - entry width constant (12 bits: result + flags)
- Sub-module arith_fifo: synchronous FIFO parameterised by DEPTH and width, with full/empty/count. The top level holds selection, flag logic and counters.

Test Plan:
- Reset: assert i_rst mid-stream with 2 entries buffered -> immediately o_valid=0, o_ready=1, o_result=0, o_flags=0, both counters 0.
- ADD a=200, b=100, i_result_add=8'h2C -> next cycle o_valid=1, o_result=8'h2C, flags=4'b0010.
- SUB a=5, b=5, result 0 -> flags=4'b0001. SUB a=3, b=5, result 8'hFE -> flags=4'b0010.
- MUL a=16, b=16, i_result_mul=0 -> o_result=0, flags=4'b0101. DIV a=7, b=0, i_result_div=8'hAA -> o_result=8'hFF, flags=4'b1000, o_count_dz=1.
- Backpressure (DEPTH=2): hold i_ready=0 and offer 3 ops continuously.
  - First two accepted; o_ready drops after the 2nd; the 3rd is held.
  - Raise i_ready: entries pop in order; the 3rd is accepted on the edge after the first pop; o_count_ops=3 after all drain.
- Saturation/wrap (CNT_W=2): 5 DIV-by-zero ops and 5 pops -> o_count_dz=3 (saturated), o_count_ops=1 (wrapped).
